shared_div_ctrl: RTL
====================

Name: shared_div_ctrl

Overview:
- Multi-cycle divide unit shared by both issue lanes of the dual-issue pipeline; services DIV, MOD, DIVU and MODU, which are removed from the single-cycle ALU path.
- Arbitrates lane requests with lane0 (older instruction) priority, then sequences a radix-2 restoring divider over 32 iterations.
- Returns one tagged result through a valid/ready response port; supports pipeline flush.

Parameters:
- DATA_W, 32: operand/result width; iteration count equals DATA_W.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  abort the current operation and discard any pending result.
- req0_valid_i  in  1  lane0 request.
- req0_ready_o  out  1  lane0 accepted when valid&ready.
- req0_op_i  in  2  00 DIV, 01 MOD, 10 DIVU, 11 MODU.
- req0_x_i  in  DATA_W  dividend.
- req0_y_i  in  DATA_W  divisor.
- req1_valid_i / req1_ready_o / req1_op_i / req1_x_i / req1_y_i: same as lane0, for lane1.
- resp_valid_o  out  1  result available.
- resp_lane_o  out  1  originating lane: 0 or 1.
- resp_data_o  out  DATA_W  quotient or remainder.
- resp_ready_i  in  1  consumer accepts the result.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; counter=0; resp_valid_o=0, resp_lane_o=0, resp_data_o=0, busy_o=0; req ready outputs follow the IDLE rules below.
- States and transitions:
  - IDLE -> PREP on an accepted request.
  - PREP -> BUSY.
  - BUSY stays 32 cycles -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE on resp_ready_i.
- Ready rules:
  - req0_ready_o = IDLE & ~flush_i.
  - req1_ready_o = IDLE & ~flush_i & ~req0_valid_i.
  - Both lanes valid in the same cycle: lane0 wins; lane1 waits.
- Capture on acceptance: op, lane, x, y.
- PREP:
  - Signed ops: take absolute values of x and y; record quotient sign = x[31]^y[31] and remainder sign = x[31].
  - Unsigned ops: operands pass unchanged.
  - Clear the partial remainder.
- BUSY: one quotient bit per cycle, MSB first.
  - Shift left {rem, quo}; subtract divisor from rem.
  - If result is non-negative, keep it and set the quotient LSB; otherwise restore.
  - Counter increments 0..31; at 31 -> FIX.
- FIX:
  - Apply sign corrections to quotient and remainder.
  - Select output: quotient for DIV/DIVU, remainder for MOD/MODU.
  - Register resp_data_o and resp_lane_o.
- DONE:
  - resp_valid_o=1; data and lane held stable until the resp_valid_o & resp_ready_i handshake.
  - Handshake returns to IDLE; a new request can be accepted one cycle later. No same-cycle back-to-back.
- Latency: resp_valid_o rises in the 35th cycle after the accepting edge (PREP 1 + BUSY 32 + FIX 1, then DONE).
- Divide by zero:
  - Quotient = all ones.
  - Remainder = x.
  - Computed naturally by the restoring algorithm for unsigned; signed forced to the same values in FIX.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Remainder sign always follows the dividend (truncating division).
- Flush:
  - From any state, the next state is IDLE and resp_valid_o drops next cycle.
  - A flush during DONE overrides resp_ready_i; the result is discarded.
- Asynchronous reset mid-operation: immediate return to the reset values; nothing is retained.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - PREP detects divisor==0, or signed overflow, or |x| < |y|.
  - Detected case goes directly PREP -> DONE with the result computed in PREP: zero-divide/overflow values above, or quotient 0 / remainder x.
  - Latency 2 cycles.
- Undefined: every operation takes the full 35-cycle path; results are identical either way.

Decomposition:
- Shared package (div_pkg): op encodings DIV_OP=2'b00, MOD_OP=2'b01, DIVU_OP=2'b10, MODU_OP=2'b11; state encodings IDLE/PREP/BUSY/FIX/DONE; DATA_W default.
- Sub-module div_iter_step: combinational single-iteration shift/subtract/select. Inputs rem, quo, divisor; outputs next rem and next quo. Instantiated once in BUSY.

Test Plan:
- Lane0 DIV x=100, y=7 -> resp after 35 cycles, lane=0, data=14. Same with MOD -> 2.
- Lane1 MOD x=0xFFFFFFF9 (-7), y=2 -> data=0xFFFFFFFF (-1). Same with DIV -> 0xFFFFFFFD (-3).
- Both lanes valid same cycle: lane0 DIVU 0xFFFFFFFF/1, lane1 DIVU 10/3.
  - Lane0 result first: 0xFFFFFFFF, lane=0.
  - Lane1 accepted after the handshake: data=3, lane=1.
- Divide by zero and overflow:
  - DIV 5/0 -> 0xFFFFFFFF; MODU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - With DIV_EARLY_OUT_EN, each of these completes in 2 cycles.
- Flush mid-op: accept DIV 100/7, assert flush_i at BUSY cycle 10 -> IDLE next cycle, no resp_valid_o; new request accepted and returns the correct result.
- Backpressure: resp_ready_i low 20 cycles in DONE -> resp_data_o/resp_lane_o stable, both req ready outputs low throughout; handshake -> IDLE.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the divide unit: op codes, FSM state codes, width.
// Imported by shared_div_ctrl and div_iter_step.
package div_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] MOD_OP  = 2'b01;
  localparam logic [1:0] DIVU_OP = 2'b10;
  localparam logic [1:0] MODU_OP = 2'b11;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] BUSY = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract.
// Ports: rem, quo, divisor in; rem_nxt, quo_nxt out.
module div_iter_step
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_nxt,
  output logic [DATA_W-1:0] quo_nxt
);

  logic [DATA_W:0]   rs;
  logic [DATA_W-1:0] diff;
  logic              ge;

  // rs needs one extra bit: a divisor near 2^DATA_W lets 2*rem overflow.
  assign rs   = {rem, quo[DATA_W-1]};
  assign ge   = rs >= {1'b0, divisor};
  assign diff = rs[DATA_W-1:0] - divisor;

  assign rem_nxt = ge ? diff : rs[DATA_W-1:0];
  assign quo_nxt = {quo[DATA_W-2:0], ge};

endmodule

// File: rtl/shared_div_ctrl.sv
// Divide unit shared by both issue lanes: arbitration, restoring divider FSM.
// Ports: two req valid/ready lanes, tagged resp valid/ready, flush, busy.
// Optional: DIV_EARLY_OUT_EN finishes trivial cases straight from PREP.
module shared_div_ctrl
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [1:0]        req0_op_i,
  input  logic [DATA_W-1:0] req0_x_i,
  input  logic [DATA_W-1:0] req0_y_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [1:0]        req1_op_i,
  input  logic [DATA_W-1:0] req1_x_i,
  input  logic [DATA_W-1:0] req1_y_i,
  output logic              resp_valid_o,
  output logic              resp_lane_o,
  output logic [DATA_W-1:0] resp_data_o,
  input  logic              resp_ready_i,
  output logic              busy_o
);

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic              lane_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;
  logic              rlane_q;

  logic              idle;
  logic              acc;
  logic              sgn;
  logic              want_rem;
  logic              y_zero;
  logic              q_neg;
  logic              r_neg;
  logic [DATA_W-1:0] abs_x;
  logic [DATA_W-1:0] abs_y;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic [DATA_W-1:0] fix_data;

  assign idle         = state == IDLE;
  assign req0_ready_o = idle & ~flush_i;
  assign req1_ready_o = idle & ~flush_i & ~req0_valid_i;
  assign acc          = (req0_valid_i & req0_ready_o)
                      | (req1_valid_i & req1_ready_o);

  assign resp_valid_o = state == DONE;
  assign resp_lane_o  = rlane_q;
  assign resp_data_o  = data_q;
  assign busy_o       = ~idle;

  assign sgn      = (op_q == DIV_OP) | (op_q == MOD_OP);
  assign want_rem = (op_q == MOD_OP) | (op_q == MODU_OP);
  assign y_zero   = y_q == '0;
  assign q_neg    = sgn & (x_q[DATA_W-1] ^ y_q[DATA_W-1]);
  assign r_neg    = sgn & x_q[DATA_W-1];

  // |0x80..0| stays 0x80..0, which is correct read as unsigned.
  assign abs_x = (sgn & x_q[DATA_W-1]) ? '0 - x_q : x_q;
  assign abs_y = (sgn & y_q[DATA_W-1]) ? '0 - y_q : y_q;

  div_iter_step #(.DATA_W(DATA_W)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Zero divisor: force results, the unsigned core would be negated.
  always_comb begin
    q_fix = q_neg ? '0 - quo_q : quo_q;
    r_fix = r_neg ? '0 - rem_q : rem_q;
    if (y_zero) begin
      q_fix = '1;
      r_fix = x_q;
    end
    fix_data = want_rem ? r_fix : q_fix;
  end

`ifdef DIV_EARLY_OUT_EN
  logic              ovf;
  logic              early;
  logic [DATA_W-1:0] early_data;

  always_comb begin
    ovf   = sgn & (x_q == {1'b1, {(DATA_W-1){1'b0}}})
                & (y_q == '1);
    early = y_zero | ovf | (abs_x < abs_y);
    early_data = want_rem ? x_q : '0;
    if (y_zero) begin
      early_data = want_rem ? x_q : '1;
    end else if (ovf) begin
      early_data = want_rem ? '0 : x_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      lane_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt     <= '0;
      data_q  <= '0;
      rlane_q <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            state  <= PREP;
            lane_q <= ~req0_valid_i;
            op_q   <= req0_valid_i ? req0_op_i : req1_op_i;
            x_q    <= req0_valid_i ? req0_x_i : req1_x_i;
            y_q    <= req0_valid_i ? req0_y_i : req1_y_i;
          end
        end
        PREP: begin
          rem_q <= '0;
          quo_q <= abs_x;
          dvs_q <= abs_y;
          cnt   <= '0;
          state <= BUSY;
`ifdef DIV_EARLY_OUT_EN
          if (early) begin
            data_q  <= early_data;
            rlane_q <= lane_q;
            state   <= DONE;
          end
`endif
        end
        BUSY: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= FIX;
        end
        FIX: begin
          data_q  <= fix_data;
          rlane_q <= lane_q;
          state   <= DONE;
        end
        DONE: begin
          if (resp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
